// File: rtl/duck_pkg.sv
// Shared state type and default game constants for the Duck Hunt round sequencer.
package duck_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_HUNT  = 3'd1,
    ST_SPAWN      = 3'd2,
    ST_FLYING     = 3'd3,
    ST_AFTER_DUCK = 3'd4,
    ST_ROUND_END  = 3'd5,
    ST_OVER       = 3'd6
  } round_state_t;

  localparam int unsigned DEF_DUCKS_PER_ROUND = 10;
  localparam int unsigned DEF_PASS_HITS       = 6;
  localparam int unsigned DEF_MAX_ROUND       = 9;
  localparam logic [2:0]  MAX_SPEED           = 3'd7;

endpackage

// File: rtl/duck_timer.sv
// Loadable 32-bit down-counter; shared by the flight and pause phases of the round sequencer.
module duck_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        dec_i,
  output logic        zero_o
);

  logic [31:0] count_q;

  // NOTE: state uses non-blocking assignments and a synchronous reset inside the clocked block,
  // so every register sees the same pre-edge values and reset needs no separate sensitivity.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 32'd1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/duck_round_ctrl.sv
// Round/duck sequencer above duck_game_logic: releases ducks, times flights and pauses,
// tallies hits per round and decides advance, loss or win.
module duck_round_ctrl
  import duck_pkg::*;
#(
  parameter int unsigned DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
  parameter int unsigned PASS_HITS       = DEF_PASS_HITS,
  parameter int unsigned MAX_ROUND       = DEF_MAX_ROUND,
  parameter int unsigned FLY_CYCLES      = 260_000_000,
  parameter int unsigned PAUSE_CYCLES    = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic       hunt_start,
  input  logic       duck_killed,
  input  logic [5:0] bullets_left,
  input  logic [2:0] bullets_in_magazine,
  output logic       game_enable,
  output logic       duck_spawn,
  output logic       duck_active,
  output logic       duck_escaped,
  output logic [2:0] duck_speed,
  output logic [3:0] round_num,
  output logic [3:0] duck_index,
  output logic [3:0] ducks_hit,
  output logic       game_over,
  output logic       game_won
);

  // Timer holds N-1 so each phase lasts exactly N cycles including the zero cycle.
  localparam logic [31:0] FLY_LOAD   = 32'(FLY_CYCLES - 1);
  localparam logic [31:0] PAUSE_LOAD = 32'(PAUSE_CYCLES - 1);
  localparam logic [3:0]  LAST_DUCK  = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0]  PASS_MIN   = 4'(PASS_HITS);
  localparam logic [3:0]  LAST_ROUND = 4'(MAX_ROUND);

  round_state_t state_q, state_d;
  logic       game_enable_q, game_enable_d;
  logic       duck_spawn_q, duck_spawn_d;
  logic       duck_active_q, duck_active_d;
  logic       duck_escaped_q, duck_escaped_d;
  logic [2:0] duck_speed_q, duck_speed_d;
  logic [3:0] round_num_q, round_num_d;
  logic [3:0] duck_index_q, duck_index_d;
  logic [3:0] ducks_hit_q, ducks_hit_d;
  logic       game_over_q, game_over_d;
  logic       game_won_q, game_won_d;
  logic       ammo_out_q, ammo_out_d;

  logic        tmr_load;
  logic [31:0] tmr_val;
  logic        tmr_dec;
  logic        tmr_zero;
  logic        ammo_empty;

  assign ammo_empty = (bullets_left == '0) && (bullets_in_magazine == '0);

  duck_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d        = state_q;
    game_enable_d  = game_enable_q;
    duck_spawn_d   = 1'b0;
    duck_active_d  = duck_active_q;
    duck_escaped_d = 1'b0;
    duck_speed_d   = duck_speed_q;
    round_num_d    = round_num_q;
    duck_index_d   = duck_index_q;
    ducks_hit_d    = ducks_hit_q;
    game_over_d    = game_over_q;
    game_won_d     = game_won_q;
    ammo_out_d     = ammo_out_q;
    tmr_load       = 1'b0;
    tmr_val        = PAUSE_LOAD;
    tmr_dec        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (game_start) begin
          state_d       = ST_WAIT_HUNT;
          game_enable_d = 1'b1;
        end
      end
      ST_WAIT_HUNT: begin
        if (hunt_start) state_d = ST_SPAWN;
      end
      ST_SPAWN: begin
        duck_spawn_d  = 1'b1;
        duck_active_d = 1'b1;
        tmr_load      = 1'b1;
        tmr_val       = FLY_LOAD;
        state_d       = ST_FLYING;
      end
      ST_FLYING: begin
        tmr_dec = 1'b1;
        // A hit outranks a simultaneous timeout or ammunition-out.
        if (duck_killed) begin
          ducks_hit_d   = ducks_hit_q + 4'd1;
          duck_active_d = 1'b0;
          tmr_load      = 1'b1;
          state_d       = ST_AFTER_DUCK;
        end else if (tmr_zero || ammo_empty) begin
          duck_escaped_d = 1'b1;
          ammo_out_d     = !tmr_zero;
          duck_active_d  = 1'b0;
          tmr_load       = 1'b1;
          state_d        = ST_AFTER_DUCK;
        end
      end
      ST_AFTER_DUCK: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          if (ammo_out_q) begin
            state_d       = ST_OVER;
            game_over_d   = 1'b1;
            game_won_d    = 1'b0;
            game_enable_d = 1'b0;
          end else if (duck_index_q == LAST_DUCK) begin
            tmr_load = 1'b1;
            state_d  = ST_ROUND_END;
          end else begin
            duck_index_d = duck_index_q + 4'd1;
            state_d      = ST_SPAWN;
          end
        end
      end
      ST_ROUND_END: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          if (ducks_hit_q < PASS_MIN) begin
            state_d       = ST_OVER;
            game_over_d   = 1'b1;
            game_won_d    = 1'b0;
            game_enable_d = 1'b0;
          end else if (round_num_q == LAST_ROUND) begin
            state_d       = ST_OVER;
            game_over_d   = 1'b1;
            game_won_d    = 1'b1;
            game_enable_d = 1'b0;
          end else begin
            round_num_d  = round_num_q + 4'd1;
            duck_speed_d = (duck_speed_q == MAX_SPEED) ? MAX_SPEED : duck_speed_q + 3'd1;
            ducks_hit_d  = '0;
            duck_index_d = '0;
            state_d      = ST_SPAWN;
          end
        end
      end
      ST_OVER: begin
        if (game_start) begin
          state_d       = ST_WAIT_HUNT;
          game_enable_d = 1'b1;
          game_over_d   = 1'b0;
          game_won_d    = 1'b0;
          ammo_out_d    = 1'b0;
          duck_speed_d  = '0;
          round_num_d   = 4'd1;
          duck_index_d  = '0;
          ducks_hit_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      game_enable_q  <= 1'b0;
      duck_spawn_q   <= 1'b0;
      duck_active_q  <= 1'b0;
      duck_escaped_q <= 1'b0;
      duck_speed_q   <= '0;
      round_num_q    <= 4'd1;
      duck_index_q   <= '0;
      ducks_hit_q    <= '0;
      game_over_q    <= 1'b0;
      game_won_q     <= 1'b0;
      ammo_out_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      game_enable_q  <= game_enable_d;
      duck_spawn_q   <= duck_spawn_d;
      duck_active_q  <= duck_active_d;
      duck_escaped_q <= duck_escaped_d;
      duck_speed_q   <= duck_speed_d;
      round_num_q    <= round_num_d;
      duck_index_q   <= duck_index_d;
      ducks_hit_q    <= ducks_hit_d;
      game_over_q    <= game_over_d;
      game_won_q     <= game_won_d;
      ammo_out_q     <= ammo_out_d;
    end
  end

  assign game_enable  = game_enable_q;
  assign duck_spawn   = duck_spawn_q;
  assign duck_active  = duck_active_q;
  assign duck_escaped = duck_escaped_q;
  assign duck_speed   = duck_speed_q;
  assign round_num    = round_num_q;
  assign duck_index   = duck_index_q;
  assign ducks_hit    = ducks_hit_q;
  assign game_over    = game_over_q;
  assign game_won     = game_won_q;

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Scoreboard bench for duck_round_ctrl with short flight/pause times and a two-round game.
module tb_duck_round_ctrl;
  import duck_pkg::*;

  localparam int F = 20;
  localparam int P = 5;

  logic       clk, rst, game_start, hunt_start, duck_killed;
  logic [5:0] bullets_left;
  logic [2:0] bullets_in_magazine;
  logic       game_enable, duck_spawn, duck_active, duck_escaped, game_over, game_won;
  logic [2:0] duck_speed;
  logic [3:0] round_num, duck_index, ducks_hit;

  duck_round_ctrl #(
    .DUCKS_PER_ROUND (10),
    .PASS_HITS       (6),
    .MAX_ROUND       (2),
    .FLY_CYCLES      (F),
    .PAUSE_CYCLES    (P)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .game_start          (game_start),
    .hunt_start          (hunt_start),
    .duck_killed         (duck_killed),
    .bullets_left        (bullets_left),
    .bullets_in_magazine (bullets_in_magazine),
    .game_enable         (game_enable),
    .duck_spawn          (duck_spawn),
    .duck_active         (duck_active),
    .duck_escaped        (duck_escaped),
    .duck_speed          (duck_speed),
    .round_num           (round_num),
    .duck_index          (duck_index),
    .ducks_hit           (ducks_hit),
    .game_over           (game_over),
    .game_won            (game_won)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         fly;
    logic       esc;
    logic [3:0] hits;
    logic [3:0] idx;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state for the spawn-time checks.
  logic [3:0] m_round, m_idx, m_hits;
  logic [2:0] m_speed;

  // Kill cycle per duck (0 = let it escape); F means a kill on the timeout cycle.
  int pats [3][10] = '{
    '{5, F, 0, 3, 0, 7, 1, 0, 0, 12},
    '{0, 2, 0, 9, 15, 0, F, 4, 0, 0},
    '{1, 1, 0, 6, 8, 0, 19, 3, 2, 0}
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: measures each duck as the DUT reports it and compares against the scoreboard.
  int         act_cnt, gap_cnt, spawn_gap;
  logic [3:0] spawn_idx;
  logic       prev_active;

  initial begin : monitor
    exp_t e;
    act_cnt = 0; gap_cnt = 0; spawn_gap = 0; spawn_idx = '0; prev_active = 1'b0;
    forever begin
      tick();
      if (rst) begin
        act_cnt = 0; gap_cnt = 0; prev_active = 1'b0;
      end else begin
        gap_cnt++;
        if (duck_spawn) begin
          spawn_gap = gap_cnt;
          spawn_idx = duck_index;
        end
        if (duck_active) act_cnt++;
        if (prev_active && !duck_active) begin
          if (sb.size() == 0) begin
            check("sb_underflow", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("fly_cycles", act_cnt, e.fly);
            check("escaped", duck_escaped, e.esc);
            check("hits_after", ducks_hit, e.hits);
            check("duck_idx", spawn_idx, e.idx);
            if (e.gap != 0) check("spawn_gap", spawn_gap, e.gap);
          end
          act_cnt = 0;
          gap_cnt = 0;
        end
        prev_active = duck_active;
      end
    end
  end

  task automatic start_game();
    game_start = 1'b1; tick(); game_start = 1'b0;
    check("enable_lat", game_enable, 1);
    check("over_clr", game_over, 0);
    check("won_clr", game_won, 0);
    check("round_init", round_num, 1);
    check("hits_init", ducks_hit, 0);
    check("idx_init", duck_index, 0);
    check("speed_init", duck_speed, 0);
    repeat (3) tick();
    check("waits_hunt", {duck_spawn, duck_active}, 0);
    hunt_start = 1'b1; tick();
    check("hunt_lat1", duck_spawn, 0);
    tick();
    check("hunt_lat2", duck_spawn, 1);
    m_round = 4'd1; m_speed = '0; m_hits = '0; m_idx = '0;
  endtask

  // Entered either at the spawn sample (spawned=1) or just after the previous duck ended.
  task automatic run_duck(input int kill_at, input int ammo_at, input int gap, input bit spawned);
    exp_t e;
    int   c;
    bit   done;
    if (!spawned) begin
      c = 0;
      while (!duck_spawn && c < 4 * P + 10) begin tick(); c++; end
      if (!duck_spawn) begin
        check("spawn_timeout", duck_spawn, 1);
        return;
      end
    end
    check("round", round_num, m_round);
    check("speed", duck_speed, m_speed);
    check("hits_at_spawn", ducks_hit, m_hits);
    check("idx_at_spawn", duck_index, m_idx);
    check("enable_on", game_enable, 1);
    e.idx = m_idx;
    e.gap = gap;
    if (kill_at > 0) begin
      m_hits = m_hits + 4'd1; e.fly = kill_at; e.esc = 1'b0;
    end else if (ammo_at > 0) begin
      e.fly = ammo_at; e.esc = 1'b1;
    end else begin
      e.fly = F; e.esc = 1'b1;
    end
    e.hits = m_hits;
    sb.push_back(e);
    done = 1'b0;
    for (int i = 1; i <= F + 3 && !done; i++) begin
      if (i == kill_at) duck_killed = 1'b1;
      if (i == ammo_at) begin bullets_left = '0; bullets_in_magazine = '0; end
      tick();
      duck_killed = 1'b0;
      if (!duck_active) done = 1'b1;
    end
    if (!done) check("fly_end", duck_active, 0);
  endtask

  task automatic run_round(input int pat, input int first_gap, input bit first_spawned);
    for (int i = 0; i < 10; i++) begin
      m_idx = 4'(i);
      run_duck(pats[pat][i], 0, (i == 0) ? first_gap : P + 1, (i == 0) && first_spawned);
    end
  endtask

  task automatic next_round();
    m_round = m_round + 4'd1;
    m_speed = m_speed + 3'd1;
    m_hits  = '0;
  endtask

  task automatic expect_over(input bit won, input int lat);
    int c = 0;
    while (!game_over && c < 4 * P + 10) begin tick(); c++; end
    check("over_latency", c, lat);
    check("game_over", game_over, 1);
    check("game_won", game_won, won);
    check("enable_off", game_enable, 0);
    check("no_active", duck_active, 0);
    hunt_start = 1'b0;
  endtask

  initial begin : driver
    rst = 1'b1; game_start = 1'b0; hunt_start = 1'b0; duck_killed = 1'b0;
    bullets_left = 6'd20; bullets_in_magazine = 3'd5;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_enable", game_enable, 0);
    check("rst_round", round_num, 1);
    check("rst_flags", {duck_spawn, duck_active, duck_escaped, game_over, game_won}, 0);
    check("rst_counts", {duck_speed, duck_index, ducks_hit}, 0);

    // Game A: pass round 1 with 6 hits, fail round 2 with 5.
    start_game();
    run_round(0, 0, 1'b1);
    next_round();
    run_round(1, 2 * P + 1, 1'b0);
    expect_over(1'b0, 2 * P);

    // Game B: restart from OVER, pass both rounds for a win.
    start_game();
    run_round(0, 0, 1'b1);
    next_round();
    run_round(2, 2 * P + 1, 1'b0);
    expect_over(1'b1, 2 * P);

    // Game C: stray kill and start pulses in the pause are ignored, then ammunition runs out.
    start_game();
    m_idx = '0;
    run_duck(4, 0, 0, 1'b1);
    duck_killed = 1'b1; game_start = 1'b1; tick();
    duck_killed = 1'b0; game_start = 1'b0;
    check("stray_kill", ducks_hit, 1);
    m_idx = 4'd1;
    run_duck(0, 6, P + 1, 1'b0);
    expect_over(1'b0, P);
    bullets_left = 6'd20; bullets_in_magazine = 3'd5;

    // Game D: reset in mid-flight.
    start_game();
    repeat (3) tick();
    check("pre_rst_active", duck_active, 1);
    rst = 1'b1; tick();
    check("rst_mid_active", duck_active, 0);
    check("rst_mid_enable", game_enable, 0);
    sb.delete();
    rst = 1'b0; hunt_start = 1'b0; tick();
    check("rst_mid_round", round_num, 1);
    check("rst_mid_idle", {duck_spawn, game_over}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
